// File: rtl/serial_link_pkg.sv
// Shared constants, register map and types for the serial link APB control block.
package serial_link_pkg;

  localparam int unsigned ApbAddrWidth = 32;
  localparam int unsigned ApbDataWidth = 32;
  localparam int unsigned ApbStrbWidth = ApbDataWidth / 8;

  // Register word offsets
  localparam logic [3:0] CtrlOffset     = 4'h0;
  localparam logic [3:0] IsolatedOffset = 4'h4;
  localparam logic [3:0] StatusOffset   = 4'h8;

  // CTRL bit positions
  localparam int unsigned CtrlClkEnaBit  = 0;
  localparam int unsigned CtrlLinkRstBit = 1;
  localparam int unsigned CtrlIsoInBit   = 8;
  localparam int unsigned CtrlIsoOutBit  = 9;

  // STATUS bit positions
  localparam int unsigned StatusToInBit    = 0;
  localparam int unsigned StatusToOutBit   = 1;
  localparam int unsigned StatusPendInBit  = 4;
  localparam int unsigned StatusPendOutBit = 5;

  localparam logic [31:0] CtrlRstVal = 32'h300;

  typedef enum logic [1:0] {
    ISOL    = 2'd0,
    DEISO   = 2'd1,
    ACTIVE  = 2'd2,
    ISO_REQ = 2'd3
  } iso_state_e;

  typedef struct packed {
    logic [ApbAddrWidth-1:0] paddr;
    logic [ApbDataWidth-1:0] pwdata;
    logic                    pwrite;
    logic                    psel;
    logic                    penable;
    logic [ApbStrbWidth-1:0] pstrb;
  } sl_apb_req_t;

  typedef struct packed {
    logic [ApbDataWidth-1:0] prdata;
    logic                    pready;
    logic                    pslverr;
  } sl_apb_rsp_t;

endpackage

// File: rtl/serial_link_iso_handshake.sv
// Isolate/de-isolate handshake tracker for one AXI isolation unit, with timeout.
module serial_link_iso_handshake
  import serial_link_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic iso_req_i,
  input  logic isolated_i,
  output logic pending_o,
  output logic timeout_o
);

  localparam int unsigned CntWidth = $clog2(TimeoutCycles);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(TimeoutCycles - 1);

  iso_state_e          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                pending_q, pending_d;
  logic                timeout_q, timeout_d;

  // Next-state: follow the requested isolation level, forcing the target state on timeout
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ISOL: begin
        if (!iso_req_i) begin
          state_d = DEISO;
          cnt_d   = '0;
        end
      end
      DEISO: begin
        if (!isolated_i) begin
          state_d = ACTIVE;
        end else if (cnt_q == CntMax) begin
          state_d   = ACTIVE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      ACTIVE: begin
        if (iso_req_i) begin
          state_d = ISO_REQ;
          cnt_d   = '0;
        end
      end
      ISO_REQ: begin
        if (isolated_i) begin
          state_d = ISOL;
        end else if (cnt_q == CntMax) begin
          state_d   = ISOL;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      default: state_d = ISOL;
    endcase
    pending_d = (state_d == DEISO) || (state_d == ISO_REQ);
  end

  // State, counter and flag registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ISOL;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      timeout_q <= timeout_d;
    end
  end

  assign pending_o = pending_q;
  assign timeout_o = timeout_q;

endmodule

// File: rtl/serial_link_apb_ctrl.sv
// APB completer for serial link CTRL / ISOLATED / STATUS registers and isolation handshake.
module serial_link_apb_ctrl
  import serial_link_pkg::*;
#(
  parameter type         apb_req_t     = sl_apb_req_t,
  parameter type         apb_rsp_t     = sl_apb_rsp_t,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  apb_req_t apb_req_i,
  output apb_rsp_t apb_rsp_o,
  output logic     clk_ena_o,
  output logic     link_rst_no,
  output logic     axi_in_isolate_o,
  output logic     axi_out_isolate_o,
  input  logic     axi_in_isolated_i,
  input  logic     axi_out_isolated_i
);

  logic                 clk_ena_q, clk_ena_d;
  logic                 link_rst_n_q, link_rst_n_d;
  logic                 iso_in_q, iso_in_d;
  logic                 iso_out_q, iso_out_d;
  logic [1:0]           ack_q;
  logic [1:0]           to_q, to_d;
  logic                 pready_q, pready_d;
  logic                 pslverr_q, pslverr_d;
  logic [DataWidth-1:0] prdata_q, prdata_d;

  logic                 in_pending, out_pending, in_timeout, out_timeout;
  logic                 access_c, addr_ok_c, mapped_c;
  logic [3:0]           word_c;
  logic                 new_clk_c, new_rst_c, new_iso_in_c, new_iso_out_c;
  logic                 illegal_c, stall_c;
  logic [1:0]           w1c_c;
  logic [DataWidth-1:0] rdata_c;
  logic                 unused_c;

  assign unused_c = ^{apb_req_i.paddr[1:0], apb_req_i.pwdata, apb_req_i.pstrb};

  // Address decode and strobe-merged CTRL candidate value
  always_comb begin
    access_c      = apb_req_i.psel && (!apb_req_i.penable || !pready_q);
    addr_ok_c     = (apb_req_i.paddr[AddrWidth-1:4] == '0);
    word_c        = {apb_req_i.paddr[3:2], 2'b00};
    mapped_c      = addr_ok_c && ((word_c == CtrlOffset) || (word_c == IsolatedOffset) ||
                                  (word_c == StatusOffset));
    new_clk_c     = apb_req_i.pstrb[0] ? apb_req_i.pwdata[CtrlClkEnaBit]  : clk_ena_q;
    new_rst_c     = apb_req_i.pstrb[0] ? apb_req_i.pwdata[CtrlLinkRstBit] : link_rst_n_q;
    new_iso_in_c  = apb_req_i.pstrb[1] ? apb_req_i.pwdata[CtrlIsoInBit]   : iso_in_q;
    new_iso_out_c = apb_req_i.pstrb[1] ? apb_req_i.pwdata[CtrlIsoOutBit]  : iso_out_q;
    illegal_c     = (!new_iso_in_c || !new_iso_out_c) && (!new_clk_c || !new_rst_c);
    stall_c       = ((new_iso_in_c != iso_in_q) && in_pending) ||
                    ((new_iso_out_c != iso_out_q) && out_pending);
  end

  // Read data mux
  always_comb begin
    rdata_c = '0;
    if (word_c == CtrlOffset) begin
      rdata_c[CtrlClkEnaBit]  = clk_ena_q;
      rdata_c[CtrlLinkRstBit] = link_rst_n_q;
      rdata_c[CtrlIsoInBit]   = iso_in_q;
      rdata_c[CtrlIsoOutBit]  = iso_out_q;
    end else if (word_c == IsolatedOffset) begin
      rdata_c[1:0] = ack_q;
    end else if (word_c == StatusOffset) begin
      rdata_c[StatusToInBit]    = to_q[0];
      rdata_c[StatusToOutBit]   = to_q[1];
      rdata_c[StatusPendInBit]  = in_pending;
      rdata_c[StatusPendOutBit] = out_pending;
    end
  end

  // APB response and register update; the response registers against setup or stalled access
  always_comb begin
    clk_ena_d    = clk_ena_q;
    link_rst_n_d = link_rst_n_q;
    iso_in_d     = iso_in_q;
    iso_out_d    = iso_out_q;
    pready_d     = 1'b0;
    pslverr_d    = 1'b0;
    prdata_d     = '0;
    w1c_c        = 2'b00;
    if (access_c) begin
      pready_d = 1'b1;
      if (!mapped_c) begin
        pslverr_d = 1'b1;
      end else if (!apb_req_i.pwrite) begin
        prdata_d = rdata_c;
      end else if (word_c == CtrlOffset) begin
        if (illegal_c) begin
          pslverr_d = 1'b1;
        end else if (stall_c) begin
          pready_d = 1'b0;
        end else begin
          clk_ena_d    = new_clk_c;
          link_rst_n_d = new_rst_c;
          iso_in_d     = new_iso_in_c;
          iso_out_d    = new_iso_out_c;
        end
      end else if ((word_c == StatusOffset) && apb_req_i.pstrb[0]) begin
        w1c_c = apb_req_i.pwdata[1:0];
      end
    end
    // New timeout beats a coincident clear
    to_d = (to_q & ~w1c_c) | {out_timeout, in_timeout};
  end

  // Register state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_ena_q    <= CtrlRstVal[CtrlClkEnaBit];
      link_rst_n_q <= CtrlRstVal[CtrlLinkRstBit];
      iso_in_q     <= CtrlRstVal[CtrlIsoInBit];
      iso_out_q    <= CtrlRstVal[CtrlIsoOutBit];
      ack_q        <= 2'b11;
      to_q         <= 2'b00;
      pready_q     <= 1'b0;
      pslverr_q    <= 1'b0;
      prdata_q     <= '0;
    end else begin
      clk_ena_q    <= clk_ena_d;
      link_rst_n_q <= link_rst_n_d;
      iso_in_q     <= iso_in_d;
      iso_out_q    <= iso_out_d;
      ack_q        <= {axi_out_isolated_i, axi_in_isolated_i};
      to_q         <= to_d;
      pready_q     <= pready_d;
      pslverr_q    <= pslverr_d;
      prdata_q     <= prdata_d;
    end
  end

  // Drive the response struct from registers
  always_comb begin
    apb_rsp_o         = '0;
    apb_rsp_o.prdata  = prdata_q;
    apb_rsp_o.pready  = pready_q;
    apb_rsp_o.pslverr = pslverr_q;
  end

  assign clk_ena_o         = clk_ena_q;
  assign link_rst_no       = link_rst_n_q;
  assign axi_in_isolate_o  = iso_in_q;
  assign axi_out_isolate_o = iso_out_q;

  serial_link_iso_handshake #(
    .TimeoutCycles(TimeoutCycles)
  ) u_hs_in (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .iso_req_i  (iso_in_q),
    .isolated_i (axi_in_isolated_i),
    .pending_o  (in_pending),
    .timeout_o  (in_timeout)
  );

  serial_link_iso_handshake #(
    .TimeoutCycles(TimeoutCycles)
  ) u_hs_out (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .iso_req_i  (iso_out_q),
    .isolated_i (axi_out_isolated_i),
    .pending_o  (out_pending),
    .timeout_o  (out_timeout)
  );

endmodule

// File: tb/tb_serial_link_apb_ctrl.sv
// Self-checking bench for serial_link_apb_ctrl with a delayed-ack isolation model.
module tb_serial_link_apb_ctrl;
  import serial_link_pkg::*;

  localparam int unsigned TO = 32;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  sl_apb_req_t req = '0;
  sl_apb_rsp_t rsp;
  logic        clk_ena, link_rst_n, iso_in, iso_out;
  logic        isolated_in, isolated_out;
  logic        hold_ack = 1'b0;
  logic [4:0]  in_pipe, out_pipe;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  serial_link_apb_ctrl #(
    .apb_req_t    (sl_apb_req_t),
    .apb_rsp_t    (sl_apb_rsp_t),
    .AddrWidth    (32),
    .DataWidth    (32),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .apb_req_i         (req),
    .apb_rsp_o         (rsp),
    .clk_ena_o         (clk_ena),
    .link_rst_no       (link_rst_n),
    .axi_in_isolate_o  (iso_in),
    .axi_out_isolate_o (iso_out),
    .axi_in_isolated_i (isolated_in),
    .axi_out_isolated_i(isolated_out)
  );

  // Isolation units: ack follows the request five cycles later, or sticks at 1 when held
  always_ff @(posedge clk) begin
    if (rst) begin
      in_pipe  <= '1;
      out_pipe <= '1;
    end else begin
      in_pipe  <= {in_pipe[3:0], iso_in};
      out_pipe <= {out_pipe[3:0], iso_out};
    end
  end
  assign isolated_in  = hold_ack ? 1'b1 : in_pipe[4];
  assign isolated_out = hold_ack ? 1'b1 : out_pipe[4];

  task automatic do_reset();
    req      = '0;
    hold_ack = 1'b0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One APB transfer; waits counts access cycles with pready low
  task automatic apb_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic err, output int waits);
    @(posedge clk); #1;
    req.paddr   = addr;
    req.pwdata  = wdata;
    req.pwrite  = wr;
    req.pstrb   = strb;
    req.psel    = 1'b1;
    req.penable = 1'b0;
    @(posedge clk); #1;
    req.penable = 1'b1;
    waits = 0;
    while (rsp.pready !== 1'b1 && waits < 200) begin
      @(posedge clk); #1;
      waits++;
    end
    if (rsp.pready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL apb_timeout addr=%h pready=%b required 1", addr, rsp.pready);
    end
    rdata = rsp.prdata;
    err   = rsp.pslverr;
    @(posedge clk); #1;
    req = '0;
  endtask

  // Scoreboarded transfer: push expectation, run, pop it back for the caller to compare
  task automatic sb_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                         input logic [3:0] strb, input logic [31:0] ed, input logic ee,
                         output logic [31:0] gd, output logic ge, output exp_t e,
                         output int waits);
    exp_q.push_back('{data: ed, err: ee});
    apb_xfer(addr, wdata, wr, strb, gd, ge, waits);
    e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    logic [31:0] gd; logic ge; exp_t e; int w;
    do_reset();
    checks++;
    if ({clk_ena, link_rst_n, iso_in, iso_out} !== 4'b0011) begin
      errors++;
      $display("FAIL reset_outputs got %b required 0011", {clk_ena, link_rst_n, iso_in, iso_out});
    end
    checks++;
    if (rsp.pready !== 1'b0 || rsp.pslverr !== 1'b0 || rsp.prdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rsp got %b/%b/%h required 0/0/0", rsp.pready, rsp.pslverr, rsp.prdata);
    end
    sb_xfer(32'h0, 0, 1'b0, 4'hf, 32'h300, 1'b0, gd, ge, e, w);
    checks++;
    if (gd !== e.data || ge !== e.err) begin
      errors++; $display("FAIL reset_ctrl got %h/%b required %h/%b", gd, ge, e.data, e.err);
    end
    sb_xfer(32'h4, 0, 1'b0, 4'hf, 32'h3, 1'b0, gd, ge, e, w);
    checks++;
    if (gd !== e.data || ge !== e.err) begin
      errors++; $display("FAIL reset_isolated got %h/%b required %h/%b", gd, ge, e.data, e.err);
    end
    sb_xfer(32'h8, 0, 1'b0, 4'hf, 32'h0, 1'b0, gd, ge, e, w);
    checks++;
    if (gd !== e.data || ge !== e.err) begin
      errors++; $display("FAIL reset_status got %h/%b required %h/%b", gd, ge, e.data, e.err);
    end
  endtask

  task automatic test_bringup();
    logic [31:0] gd; logic ge; exp_t e; int w;
    logic [31:0] seq [4];
    bit done;
    seq = '{32'h300, 32'h302, 32'h303, 32'h003};
    for (int i = 0; i < 4; i++) begin
      sb_xfer(32'h0, seq[i], 1'b1, 4'hf, 32'h0, 1'b0, gd, ge, e, w);
      checks++;
      if (ge !== e.err || w != 0) begin
        errors++;
        $display("FAIL bringup_wr%0d err=%b waits=%0d required %b/0", i, ge, w, e.err);
      end
    end
    sb_xfer(32'h8, 0, 1'b0, 4'hf, 32'h30, 1'b0, gd, ge, e, w);
    checks++;
    if (gd !== e.data || ge !== e.err) begin
      errors++; $display("FAIL bringup_pending got %h required %h", gd, e.data);
    end
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      apb_xfer(32'h4, 0, 1'b0, 4'hf, gd, ge, w);
      if (gd === 32'h0) done = 1'b1;
      else begin
        checks++;
        if (gd !== 32'h3) begin
          errors++; $display("FAIL bringup_poll got %h required 3", gd);
        end
      end
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL bringup_isolated_clear got %h required 0", gd);
    end
    sb_xfer(32'h8, 0, 1'b0, 4'hf, 32'h0, 1'b0, gd, ge, e, w);
    checks++;
    if (gd !== e.data || ge !== e.err) begin
      errors++; $display("FAIL bringup_status got %h required %h", gd, e.data);
    end
    checks++;
    if ({clk_ena, link_rst_n, iso_in, iso_out} !== 4'b1100) begin
      errors++;
      $display("FAIL bringup_outputs got %b required 1100", {clk_ena, link_rst_n, iso_in, iso_out});
    end
  endtask

  task automatic test_illegal();
    logic [31:0] gd; logic ge; exp_t e; int w;
    do_reset();
    sb_xfer(32'h0, 32'h001, 1'b1, 4'hf, 32'h0, 1'b1, gd, ge, e, w);
    checks++;
    if (ge !== e.err || w != 0) begin
      errors++; $display("FAIL illegal_err got %b waits=%0d required %b/0", ge, w, e.err);
    end
    sb_xfer(32'h0, 0, 1'b0, 4'hf, 32'h300, 1'b0, gd, ge, e, w);
    checks++;
    if (gd !== e.data || ge !== e.err) begin
      errors++; $display("FAIL illegal_ctrl got %h required %h", gd, e.data);
    end
    checks++;
    if ({clk_ena, iso_in, iso_out} !== 3'b011) begin
      errors++; $display("FAIL illegal_outputs got %b required 011", {clk_ena, iso_in, iso_out});
    end
  endtask

  task automatic test_stall();
    logic [31:0] gd; logic ge; exp_t e; int w;
    do_reset();
    apb_xfer(32'h0, 32'h303, 1'b1, 4'hf, gd, ge, w);
    // Byte-1 strobe only: isolate bits drop, enables kept
    apb_xfer(32'h0, 32'h000, 1'b1, 4'h2, gd, ge, w);
    sb_xfer(32'h0, 0, 1'b0, 4'hf, 32'h003, 1'b0, gd, ge, e, w);
    checks++;
    if (gd !== e.data || ge !== e.err) begin
      errors++; $display("FAIL strobe_ctrl got %h required %h", gd, e.data);
    end
    sb_xfer(32'h0, 32'h103, 1'b1, 4'hf, 32'h0, 1'b0, gd, ge, e, w);
    checks++;
    if (ge !== e.err || w == 0) begin
      errors++; $display("FAIL stall_wait err=%b waits=%0d required %b/nonzero", ge, w, e.err);
    end
    sb_xfer(32'h0, 0, 1'b0, 4'hf, 32'h103, 1'b0, gd, ge, e, w);
    checks++;
    if (gd !== e.data || ge !== e.err) begin
      errors++; $display("FAIL stall_ctrl got %h required %h", gd, e.data);
    end
    sb_xfer(32'h8, 0, 1'b0, 4'hf, 32'h10, 1'b0, gd, ge, e, w);
    checks++;
    if (gd !== e.data || ge !== e.err) begin
      errors++; $display("FAIL stall_status got %h required %h", gd, e.data);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] gd; logic ge; exp_t e; int w;
    do_reset();
    apb_xfer(32'h0, 32'h303, 1'b1, 4'hf, gd, ge, w);
    hold_ack = 1'b1;
    apb_xfer(32'h0, 32'h003, 1'b1, 4'hf, gd, ge, w);
    sb_xfer(32'h8, 0, 1'b0, 4'hf, 32'h30, 1'b0, gd, ge, e, w);
    checks++;
    if (gd !== e.data || ge !== e.err) begin
      errors++; $display("FAIL to_pending got %h required %h", gd, e.data);
    end
    repeat (TO + 5) @(posedge clk);
    sb_xfer(32'h8, 0, 1'b0, 4'hf, 32'h03, 1'b0, gd, ge, e, w);
    checks++;
    if (gd !== e.data || ge !== e.err) begin
      errors++; $display("FAIL to_sticky got %h required %h", gd, e.data);
    end
    sb_xfer(32'h4, 0, 1'b0, 4'hf, 32'h3, 1'b0, gd, ge, e, w);
    checks++;
    if (gd !== e.data || ge !== e.err) begin
      errors++; $display("FAIL to_isolated got %h required %h", gd, e.data);
    end
    // W1C without byte-0 strobe leaves both bits set
    apb_xfer(32'h8, 32'h3, 1'b1, 4'h2, gd, ge, w);
    sb_xfer(32'h8, 0, 1'b0, 4'hf, 32'h03, 1'b0, gd, ge, e, w);
    checks++;
    if (gd !== e.data || ge !== e.err) begin
      errors++; $display("FAIL to_nostrb got %h required %h", gd, e.data);
    end
    apb_xfer(32'h8, 32'h1, 1'b1, 4'h1, gd, ge, w);
    sb_xfer(32'h8, 0, 1'b0, 4'hf, 32'h02, 1'b0, gd, ge, e, w);
    checks++;
    if (gd !== e.data || ge !== e.err) begin
      errors++; $display("FAIL to_w1c got %h required %h", gd, e.data);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] gd; logic ge; exp_t e; int w;
    sb_xfer(32'hC, 0, 1'b0, 4'hf, 32'h0, 1'b1, gd, ge, e, w);
    checks++;
    if (gd !== e.data || ge !== e.err) begin
      errors++; $display("FAIL unmapped_rd got %h/%b required %h/%b", gd, ge, e.data, e.err);
    end
    sb_xfer(32'h10, 32'h300, 1'b1, 4'hf, 32'h0, 1'b1, gd, ge, e, w);
    checks++;
    if (gd !== e.data || ge !== e.err) begin
      errors++; $display("FAIL unmapped_wr got %h/%b required %h/%b", gd, ge, e.data, e.err);
    end
    sb_xfer(32'h0, 0, 1'b0, 4'hf, 32'h003, 1'b0, gd, ge, e, w);
    checks++;
    if (gd !== e.data || ge !== e.err) begin
      errors++; $display("FAIL unmapped_ctrl got %h required %h", gd, e.data);
    end
    sb_xfer(32'h8, 0, 1'b0, 4'hf, 32'h02, 1'b0, gd, ge, e, w);
    checks++;
    if (gd !== e.data || ge !== e.err) begin
      errors++; $display("FAIL unmapped_status got %h required %h", gd, e.data);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] gd; logic ge; int w;
    do_reset();
    apb_xfer(32'h0, 32'h303, 1'b1, 4'hf, gd, ge, w);
    apb_xfer(32'h0, 32'h003, 1'b1, 4'hf, gd, ge, w);
    hold_ack = 1'b1;
    @(posedge clk); #1;
    req.paddr = 32'h0; req.pwdata = 32'h103; req.pwrite = 1'b1; req.pstrb = 4'hf;
    req.psel = 1'b1; req.penable = 1'b0;
    @(posedge clk); #1 req.penable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rsp.pready !== 1'b0) begin
      errors++; $display("FAIL mid_stall pready=%b required 0", rsp.pready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    req = '0;
    rst = 1'b0;
    checks++;
    if (rsp.pready !== 1'b0 || {clk_ena, link_rst_n, iso_in, iso_out} !== 4'b0011) begin
      errors++;
      $display("FAIL mid_reset got %b/%b required 0/0011", rsp.pready,
               {clk_ena, link_rst_n, iso_in, iso_out});
    end
    hold_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_illegal();
    test_stall();
    test_timeout();
    test_unmapped();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_link_apb_ctrl.md
Name: serial_link_apb_ctrl

Overview:
- APB completer holding the serial link control/status registers. It answers the config-bus initiator's CTRL writes and ISOLATED polls.
- Drives link clock enable, link reset and the AXI isolation requests.
- Tracks the isolate/de-isolate handshake with the two AXI isolation units, with per-port timeout detection.
- Sits between the config APB port and the link datapath, in the link's system clock domain.

Parameters:
- apb_req_t, type, APB request struct (paddr, pwdata, pwrite, psel, penable, pstrb).
- apb_rsp_t, type, APB response struct (prdata, pready, pslverr).
- AddrWidth, 32, APB address width; only paddr[3:2] decoded, paddr[AddrWidth-1:4] must be 0.
- DataWidth, 32, APB data width.
- TimeoutCycles, 1024, max cycles a port handshake may stay pending; must be >=2.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- apb_req_i  in  apb_req_t  config request
- apb_rsp_o  out  apb_rsp_t  config response
- clk_ena_o  out  1  link clock enable (CTRL[0])
- link_rst_no  out  1  link reset, active-low (CTRL[1])
- axi_in_isolate_o  out  1  isolate request, AXI in port (CTRL[8])
- axi_out_isolate_o  out  1  isolate request, AXI out port (CTRL[9])
- axi_in_isolated_i  in  1  isolation ack, AXI in port
- axi_out_isolated_i  in  1  isolation ack, AXI out port

Behaviour:
- Register map (word offsets):
  - 0x0 CTRL, RW, reset 0x300; bits [0],[1],[8],[9]; other bits read 0.
  - 0x4 ISOLATED, RO; [0] in, [1] out. Holds registered acks (1-cycle lag); reset 0x3.
  - 0x8 STATUS: [0] in_timeout and [1] out_timeout, sticky RW1C; [4] in_pending and [5] out_pending, RO. Reset 0x0.
- Unmapped address -> pslverr=1, prdata=0, no state change.
- Reset values of outputs: clk_ena_o=0, link_rst_no=0, both isolate_o=1, pready=0, pslverr=0, prdata=0.
- APB access timing:
  - Setup phase (psel & !penable): no response.
  - Access phase: pready=1 in the same cycle (registered against the setup decode), so reads and non-stalling writes have zero wait states.
  - prdata is valid only when pready=1, else 0.
- pstrb: byte 0 gates CTRL[1:0]; byte 1 gates CTRL[9:8]; byte 0 gates the STATUS W1C bits.
- Stall rule: a CTRL write that changes an isolate bit whose port is pending holds pready=0 until that port is not pending, then commits.
  - A timeout clears pending, so the stall always ends within TimeoutCycles+1 cycles.
- Illegal write: a CTRL write whose new value has an isolate bit =0 while new clk_ena=0 or new link_rst_n=0 -> pslverr=1 and the whole write is dropped.
- Per-port FSM, states ISOL, DEISO, ACTIVE, ISO_REQ:
  - ISOL -> DEISO when the isolate bit is written 0.
  - DEISO -> ACTIVE when isolated_i==0.
  - ACTIVE -> ISO_REQ when the isolate bit is written 1.
  - ISO_REQ -> ISOL when isolated_i==1.
  - pending = state in {DEISO, ISO_REQ}.
- Timeout counter:
  - Cleared on entry to DEISO or ISO_REQ; increments each pending cycle.
  - At count==TimeoutCycles-1 without ack: FSM moves to its target state and the sticky timeout bit is set.
  - Ack and timeout in the same cycle -> ack wins, no sticky set.
  - Saturates; never wraps.
- Writing the isolate bit to its current value causes no transition.
- W1C of a timeout bit coincident with a new timeout -> bit stays 1 (set wins).
- rst_i asserted mid-transfer or mid-handshake: all registers and FSMs return to reset values next edge; an in-flight APB access is abandoned with pready=0.

Decomposition:
- serial_link_pkg gets:
  - register offsets CtrlOffset=0x0, IsolatedOffset=0x4, StatusOffset=0x8;
  - CTRL bit positions;
  - the iso_state_e enum;
  - CtrlRstVal=32'h300.
- One sub-module, serial_link_iso_handshake: per-port FSM plus timeout counter, instantiated twice (in, out).

Test Plan:
- Reset -> read CTRL=0x300, ISOLATED=0x3, STATUS=0x0; clk_ena_o=0, link_rst_no=0, both isolate_o=1.
- Write CTRL 0x300, 0x302, 0x303, then 0x003; bench isolation model drops acks 5 cycles later:
  - STATUS reads 0x30 while pending;
  - ISOLATED polls 0x3 until it reads 0x0;
  - all writes pready on first access cycle, pslverr=0.
- Write CTRL 0x001 (isolate off, link_rst_n=0) -> pslverr=1; CTRL reads 0x300 afterwards.
- With in-port pending, write CTRL 0x103 -> pready low until ack arrives, then CTRL reads 0x103.
- Acks held at 1 after writing 0x003 -> after TimeoutCycles cycles STATUS=0x03, FSMs ACTIVE. Write STATUS 0x1 -> STATUS=0x02.
- Read address 0xC and write 0x10 -> pslverr=1, prdata=0; registers unchanged.
